gpr_bank: RTL and testbench

- Parametrised successor to the fixed 8x16 general-purpose register file: WIDTH-bit registers, NREGS entries, on the shared tristate DATA bus.
- Keeps the existing selection model: select code plus Rd/Rs fields from the instruction decoder.
- R0 always reads zero. Top register is the program counter and has a hardware increment.
- Adds a bus-free register-to-register copy engine (req/busy/done handshake) and sticky bus-conflict detection.

---
 rtl/gpr_pkg.sv | 23 ++
 rtl/gpr_copy_fsm.sv | 75 +++++++
 rtl/gpr_bank.sv | 127 ++++++++++++
 tb/tb_gpr_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared definitions for the parametrised general-purpose register bank:
// bus select codes, copy engine states and the PC index helper.
package gpr_pkg;

   localparam logic [2:0] SEL_ZERO = 3'b000;
   localparam logic [2:0] SEL_PC   = 3'b001;
   localparam logic [2:0] SEL_RD1  = 3'b010;
   localparam logic [2:0] SEL_RD2  = 3'b011;
   localparam logic [2:0] SEL_RS1  = 3'b100;
   localparam logic [2:0] SEL_RS2  = 3'b101;

   typedef enum logic [1:0] {
      CP_IDLE  = 2'd0,
      CP_READ  = 2'd1,
      CP_WRITE = 2'd2
   } copy_state_e;

   // The program counter always occupies the top register.
   function automatic int pc_index(input int nregs);
      return nregs - 1;
   endfunction

endpackage

// File: rtl/gpr_copy_fsm.sv
// Register-to-register copy engine: latches indices, reads the source into
// a holding register, then issues a single write to the destination.
module gpr_copy_fsm
   import gpr_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] src_i,
   input  logic [ADDR_W-1:0] dst_i,
   output logic [ADDR_W-1:0] rd_idx_o,
   input  logic [WIDTH-1:0]  rd_data_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_idx_o,
   output logic [WIDTH-1:0]  wr_data_o,
   output logic              busy_o,
   output logic              done_o
);

   copy_state_e       state_q, state_d;
   logic [ADDR_W-1:0] src_q, dst_q;
   logic [WIDTH-1:0]  tmp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Indices and the held value are only consumed in READ/WRITE, so they need no reset.
   always_ff @(posedge clk) begin
      if (state_q == CP_IDLE && req_i) begin
         src_q <= src_i;
         dst_q <= dst_i;
      end
      if (state_q == CP_READ) begin
         tmp_q <= rd_data_i;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_en_o = 1'b0;
      done_o  = 1'b0;
      busy_o  = 1'b1;
      unique case (state_q)
         CP_IDLE: begin
            busy_o = 1'b0;
            if (req_i) state_d = CP_READ;
         end
         CP_READ: begin
            state_d = CP_WRITE;
         end
         CP_WRITE: begin
            done_o  = 1'b1;
            wr_en_o = 1'b1;
            state_d = CP_IDLE;
         end
         default: begin
            busy_o  = 1'b0;
            state_d = CP_IDLE;
         end
      endcase
   end

   assign rd_idx_o  = src_q;
   assign wr_idx_o  = dst_q;
   assign wr_data_o = tmp_q;

endmodule

// File: rtl/gpr_bank.sv
// Parametrised register bank on the shared tristate DATA bus with PC increment,
// copy engine and sticky conflict flag. Define GPR_DEBUG_EN for the dbg read port.
module gpr_bank
   import gpr_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter int               NREGS     = 8,
   parameter int               PC_STEP   = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              ADDR_W    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   inout  wire  [WIDTH-1:0]  DATA,
   output logic [WIDTH-1:0]  REG_OUT_1,
   output logic [WIDTH-1:0]  REG_OUT_PC,
   input  logic              GPR_in,
   input  logic              GPR_out,
   input  logic [2:0]        GPR_select,
   input  logic [ADDR_W-1:0] Rd_1,
   input  logic [ADDR_W-1:0] Rd_2,
   input  logic [ADDR_W-1:0] Rs_1,
   input  logic [ADDR_W-1:0] Rs_2,
   input  logic              pc_inc,
   input  logic              copy_req,
   input  logic [ADDR_W-1:0] copy_src,
   input  logic [ADDR_W-1:0] copy_dst,
   output logic              busy,
   output logic              copy_done,
   output logic              err_conflict
`ifdef GPR_DEBUG_EN
   ,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [WIDTH-1:0]  dbg_data
`endif
);

   localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(pc_index(NREGS));
   localparam logic [WIDTH-1:0]  STEP   = WIDTH'(PC_STEP);

   logic [WIDTH-1:0]  rf [NREGS];
   logic [ADDR_W-1:0] sel_idx, cp_rd_idx, cp_wr_idx;
   logic [WIDTH-1:0]  cp_wr_data;
   logic              cp_wr_en, bus_rd, bus_wr;
   logic              err_q, err_d;

   always_comb begin
      sel_idx = '0;
      case (GPR_select)
         SEL_PC:  sel_idx = PC_IDX;
         SEL_RD1: sel_idx = Rd_1;
         SEL_RD2: sel_idx = Rd_2;
         SEL_RS1: sel_idx = Rs_1;
         SEL_RS2: sel_idx = Rs_2;
         default: sel_idx = '0;
      endcase
   end

   assign bus_rd = GPR_out & ~GPR_in & ~busy;
   assign bus_wr = GPR_in & ~GPR_out & ~busy;
   assign DATA   = bus_rd ? rf[sel_idx] : {WIDTH{1'bz}};

   // R0 has no storage; every write aimed at it simply finds no register.
   assign rf[0] = '0;

   for (genvar i = 1; i < NREGS; i++) begin : g_reg
      logic [WIDTH-1:0] r_q, r_d;

      always_comb begin
         r_d = r_q;
         if (bus_wr && sel_idx == ADDR_W'(i)) begin
            r_d = DATA;
         end else if (cp_wr_en && cp_wr_idx == ADDR_W'(i)) begin
            r_d = cp_wr_data;
         end else if (pc_inc && ADDR_W'(i) == PC_IDX) begin
            r_d = r_q + STEP;
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_q <= RESET_VAL;
         end else begin
            r_q <= r_d;
         end
      end

      assign rf[i] = r_q;
   end

   assign err_d = err_q | (GPR_in & GPR_out);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   gpr_copy_fsm #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_copy (
      .clk       (clk),
      .rst_n     (reset),
      .req_i     (copy_req),
      .src_i     (copy_src),
      .dst_i     (copy_dst),
      .rd_idx_o  (cp_rd_idx),
      .rd_data_i (rf[cp_rd_idx]),
      .wr_en_o   (cp_wr_en),
      .wr_idx_o  (cp_wr_idx),
      .wr_data_o (cp_wr_data),
      .busy_o    (busy),
      .done_o    (copy_done)
   );

   assign REG_OUT_1    = rf[1];
   assign REG_OUT_PC   = rf[PC_IDX];
   assign err_conflict = err_q;

`ifdef GPR_DEBUG_EN
   assign dbg_data = rf[dbg_addr];
`endif

endmodule

// File: tb/tb_gpr_bank.sv
// Directed plus randomized bench for gpr_bank against an array-based register model.
module tb_gpr_bank;

   localparam int W  = 16;
   localparam int N  = 8;
   localparam int PC = N - 1;

   logic         clk = 1'b0;
   logic         reset;
   wire  [W-1:0] DATA;
   logic [W-1:0] drv;
   logic         drv_en;
   logic [W-1:0] REG_OUT_1, REG_OUT_PC;
   logic         GPR_in, GPR_out;
   logic [2:0]   GPR_select;
   logic [2:0]   Rd_1, Rd_2, Rs_1, Rs_2;
   logic         pc_inc, copy_req;
   logic [2:0]   copy_src, copy_dst;
   logic         busy, copy_done, err_conflict;
`ifdef GPR_DEBUG_EN
   logic [2:0]   dbg_addr;
   logic [W-1:0] dbg_data;
`endif

   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] m [N];

   always #5 clk = ~clk;

   // When the bench expects the DUT to be off the bus it drives zero itself,
   // so any DUT drive of a nonzero register shows up as a wrong value.
   assign DATA = drv_en ? drv : {W{1'bz}};

   gpr_bank dut (
      .clk          (clk),
      .reset        (reset),
      .DATA         (DATA),
      .REG_OUT_1    (REG_OUT_1),
      .REG_OUT_PC   (REG_OUT_PC),
      .GPR_in       (GPR_in),
      .GPR_out      (GPR_out),
      .GPR_select   (GPR_select),
      .Rd_1         (Rd_1),
      .Rd_2         (Rd_2),
      .Rs_1         (Rs_1),
      .Rs_2         (Rs_2),
      .pc_inc       (pc_inc),
      .copy_req     (copy_req),
      .copy_src     (copy_src),
      .copy_dst     (copy_dst),
      .busy         (busy),
      .copy_done    (copy_done),
      .err_conflict (err_conflict)
`ifdef GPR_DEBUG_EN
      ,
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
`endif
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int dec(input logic [2:0] s);
      case (s)
         3'b001:  return PC;
         3'b010:  return int'(Rd_1);
         3'b011:  return int'(Rd_2);
         3'b100:  return int'(Rs_1);
         3'b101:  return int'(Rs_2);
         default: return 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m[i] = '0;
   endtask

   task automatic do_write(input logic [2:0] sel, input logic [W-1:0] val, input logic inc);
      int k;
      GPR_select = sel; GPR_in = 1'b1; drv_en = 1'b1; drv = val; pc_inc = inc;
      k = dec(sel);
      tick();
      if (inc) m[PC] = m[PC] + 16'd1;
      if (k != 0) m[k] = val;
      GPR_in = 1'b0; drv_en = 1'b0; pc_inc = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] sel, input string tag);
      GPR_select = sel; GPR_out = 1'b1; drv_en = 1'b0;
      #1;
      chk(tag, DATA, m[dec(sel)]);
      GPR_out = 1'b0;
   endtask

   task automatic do_inc();
      pc_inc = 1'b1;
      tick();
      m[PC] = m[PC] + 16'd1;
      pc_inc = 1'b0;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".r1"}, REG_OUT_1, m[1]);
      chk({tag, ".pc"}, REG_OUT_PC, m[PC]);
   endtask

   task automatic do_copy(input logic [2:0] src, input logic [2:0] dst, input logic [2:0] incs);
      logic [W-1:0] tmp;
      copy_req = 1'b1; copy_src = src; copy_dst = dst; pc_inc = incs[0];
      tick();
      copy_req = 1'b0;
      if (incs[0]) m[PC] = m[PC] + 16'd1;
      chk("cp.busy1", {15'd0, busy}, 16'd1);
      chk("cp.done1", {15'd0, copy_done}, 16'd0);
      pc_inc = incs[1];
      tmp = m[src];
      tick();
      if (incs[1]) m[PC] = m[PC] + 16'd1;
      chk("cp.busy2", {15'd0, busy}, 16'd1);
      chk("cp.done2", {15'd0, copy_done}, 16'd1);
      pc_inc = incs[2];
      tick();
      if (incs[2]) m[PC] = m[PC] + 16'd1;
      if (dst != 3'd0) m[dst] = tmp;
      pc_inc = 1'b0;
      chk("cp.busy3", {15'd0, busy}, 16'd0);
      chk("cp.done3", {15'd0, copy_done}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; drv = '0; drv_en = 1'b0; GPR_in = 1'b0; GPR_out = 1'b0;
      GPR_select = 3'd0; Rd_1 = 3'd0; Rd_2 = 3'd0; Rs_1 = 3'd0; Rs_2 = 3'd0;
      pc_inc = 1'b0; copy_req = 1'b0; copy_src = 3'd0; copy_dst = 3'd0;
`ifdef GPR_DEBUG_EN
      dbg_addr = 3'd0;
`endif
      model_reset();
      tick(); tick();
      reset = 1'b1;
      tick();

      // Reset state
      chk("rst.busy", {15'd0, busy}, 16'd0);
      chk("rst.done", {15'd0, copy_done}, 16'd0);
      chk("rst.err", {15'd0, err_conflict}, 16'd0);
      chk_outs("rst");
      do_read(3'b001, "rst.pc_read");

      // Bus write/read and R0 behaviour
      Rd_1 = 3'd3;
      do_write(3'b010, 16'hBEEF, 1'b0);
      do_read(3'b010, "rd1.r3");
      do_write(3'b000, 16'h1234, 1'b0);
      do_read(3'b000, "r0.sel0");
      Rd_2 = 3'd0;
      do_write(3'b011, 16'h4321, 1'b0);
      do_read(3'b011, "r0.rd2");
      do_read(3'b110, "sel110");
      Rs_2 = 3'd1;
      do_write(3'b101, 16'h0F0F, 1'b0);
      chk_outs("r1w");

      // PC wrap and write-over-increment priority
      do_write(3'b001, 16'hFFFF, 1'b0);
      do_inc();
      do_inc();
      chk("pc.wrap", REG_OUT_PC, 16'h0001);
      do_write(3'b001, 16'h0100, 1'b1);
      chk("pc.override", REG_OUT_PC, 16'h0100);

      // Directed copy R2 -> R5, bus ignored while busy, late copy_req ignored
      Rs_1 = 3'd2;
      do_write(3'b100, 16'h00AA, 1'b0);
      copy_req = 1'b1; copy_src = 3'd2; copy_dst = 3'd5;
      tick();
      copy_dst = 3'd6;
      chk("dcp.busy1", {15'd0, busy}, 16'd1);
      chk("dcp.done1", {15'd0, copy_done}, 16'd0);
      GPR_select = 3'b100; GPR_out = 1'b1; drv_en = 1'b1; drv = '0;
      #1;
      chk("dcp.busread_z", DATA, 16'h0000);
      GPR_out = 1'b0; drv_en = 1'b0;
      tick();
      copy_req = 1'b0;
      chk("dcp.busy2", {15'd0, busy}, 16'd1);
      chk("dcp.done2", {15'd0, copy_done}, 16'd1);
      tick();
      m[5] = 16'h00AA;
      chk("dcp.busy3", {15'd0, busy}, 16'd0);
      chk("dcp.done3", {15'd0, copy_done}, 16'd0);
      Rs_2 = 3'd5;
      do_read(3'b101, "dcp.r5");
      Rs_2 = 3'd6;
      do_read(3'b101, "dcp.r6_untouched");
      chk("dcp.err", {15'd0, err_conflict}, 16'd0);

      // Bus conflict
      Rd_1 = 3'd3;
      GPR_select = 3'b010; GPR_in = 1'b1; GPR_out = 1'b1; drv_en = 1'b1; drv = '0;
      #1;
      chk("cf.nodrive", DATA, 16'h0000);
      tick();
      GPR_in = 1'b0; GPR_out = 1'b0; drv_en = 1'b0;
      chk("cf.err", {15'd0, err_conflict}, 16'd1);
      do_read(3'b010, "cf.r3_kept");

      // Randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         Rd_1 = 3'($urandom_range(0, 7));
         Rd_2 = 3'($urandom_range(0, 7));
         Rs_1 = 3'($urandom_range(0, 7));
         Rs_2 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: do_write(3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
            1: do_read(3'($urandom_range(0, 7)), "rnd.read");
            2: do_inc();
            default: do_copy(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                             3'($urandom_range(0, 7)));
         endcase
         chk_outs("rnd");
      end
      do_copy(3'd7, 3'd3, 3'b011);
      Rd_1 = 3'd3;
      do_read(3'b010, "cp.pc_src");
      chk("rnd.err_sticky", {15'd0, err_conflict}, 16'd1);

      // Reset in the middle of a copy
      Rd_1 = 3'd4;
      do_write(3'b010, 16'h0011, 1'b0);
      Rs_1 = 3'd2;
      do_write(3'b100, 16'h00AA, 1'b0);
      copy_req = 1'b1; copy_src = 3'd2; copy_dst = 3'd4;
      tick();
      copy_req = 1'b0;
      chk("mr.busy_read", {15'd0, busy}, 16'd1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("mr.busy", {15'd0, busy}, 16'd0);
      chk("mr.done", {15'd0, copy_done}, 16'd0);
      chk("mr.err", {15'd0, err_conflict}, 16'd0);
      chk_outs("mr");
      tick();
      chk("mr.done_hold", {15'd0, copy_done}, 16'd0);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mr.done_after", {15'd0, copy_done}, 16'd0);
         chk("mr.busy_after", {15'd0, busy}, 16'd0);
      end
      do_read(3'b010, "mr.r4");
`ifdef GPR_DEBUG_EN
      dbg_addr = 3'd4;
      #1;
      chk("dbg.r4", dbg_data, m[4]);
      Rs_2 = 3'd6;
      do_write(3'b101, 16'h5A5A, 1'b0);
      dbg_addr = 3'd6;
      #1;
      chk("dbg.r6", dbg_data, m[6]);
      dbg_addr = 3'd0;
      #1;
      chk("dbg.r0", dbg_data, 16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
